rip_lsu: RTL and testbench

//  Load/store unit between the execute stage and rip_memory. Accepts one load/store per handshake and holds the memory request stable while mem_busy.

---
 rtl/rip_lsu_pkg.sv | 46 ++++
 rtl/rip_load_align.sv | 28 ++
 rtl/rip_lsu.sv | 141 ++++++++++++++
 tb/tb_rip_lsu.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rip_lsu_pkg.sv
// Shared constants and types for the rip load/store unit.
package rip_lsu_pkg;

   localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE = 7'b0100011;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} lsu_state_e;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
   } inst_t;

   // Access size is carried in funct3[1:0] for both loads and stores:
   // 00 byte, 01 half, anything else behaves as a word.
   function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] addr_lo);
      logic mis;
      case (funct3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = addr_lo[0];
         default: mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

   // Low address bits after forcing natural alignment for the access size.
   function automatic logic [1:0] align_lo(logic [2:0] funct3, logic [1:0] addr_lo);
      logic [1:0] lo;
      case (funct3[1:0])
         2'b00:   lo = addr_lo;
         2'b01:   lo = {addr_lo[1], 1'b0};
         default: lo = 2'b00;
      endcase
      return lo;
   endfunction

endpackage

// File: rtl/rip_load_align.sv
// Load data extraction: picks the addressed byte/half out of the returned
// word and sign- or zero-extends it according to funct3.
module rip_load_align
   import rip_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select followed by extension; unknown funct3 returns the whole word.
   always_comb begin
      byte_sel = word[{addr_lo, 3'b000} +: 8];
      half_sel = word[{addr_lo[1], 4'b0000} +: 16];
      case (funct3)
         LB:      result = {{24{byte_sel[7]}}, byte_sel};
         LH:      result = {{16{half_sel[15]}}, half_sel};
         LBU:     result = {24'd0, byte_sel};
         LHU:     result = {16'd0, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/rip_lsu.sv
// rip_lsu: load/store unit between execute and rip_memory.
// Optional feature macro: RIP_LSU_MISALIGN_TRAP_EN (misaligned requests
// fault without touching memory; otherwise the address is force-aligned).
//
// state   | meaning
// IDLE    | ready for a new request
// ISSUE   | strobe to memory, held while mem_busy
// WAIT_RD | read data returning, extract and extend
// RESP    | response presented until rsp_ready
module rip_lsu
   import rip_lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  inst_t                 req_inst,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_misalign,
   output inst_t                 mem_inst,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_busy
);

   lsu_state_e            state_q, state_d;
   inst_t                 inst_q, inst_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_mis_q, rsp_mis_d;

   logic                  req_is_mem;
   logic                  is_load_q;
   logic                  is_store_q;
   logic [31:0]           load_result;

   assign req_is_mem = (req_inst.opcode == OPCODE_LOAD) || (req_inst.opcode == OPCODE_STORE);
   assign is_load_q  = (inst_q.opcode == OPCODE_LOAD);
   assign is_store_q = (inst_q.opcode == OPCODE_STORE);

   rip_load_align u_align (
      .funct3  (inst_q.funct3),
      .addr_lo (addr_q[1:0]),
      .word    (mem_rdata),
      .result  (load_result)
   );

   // Next-state and datapath capture for the request/response sequence.
   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rsp_data_d = rsp_data_q;
      rsp_mis_d  = rsp_mis_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               inst_d     = req_inst;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               rsp_data_d = '0;
               rsp_mis_d  = 1'b0;
               if (!req_is_mem) begin
                  state_d = RESP;
`ifdef RIP_LSU_MISALIGN_TRAP_EN
               end else if (is_misaligned(req_inst.funct3, req_addr[1:0])) begin
                  state_d    = RESP;
                  rsp_mis_d  = 1'b1;
                  rsp_data_d = DATA_WIDTH'(req_addr);
               end else begin
                  state_d = ISSUE;
               end
`else
               end else begin
                  addr_d[1:0] = align_lo(req_inst.funct3, req_addr[1:0]);
                  state_d     = ISSUE;
               end
`endif
            end
         end
         ISSUE: begin
            if (!mem_busy) begin
               state_d = is_load_q ? WAIT_RD : RESP;
            end
         end
         WAIT_RD: begin
            rsp_data_d = load_result;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched request/response registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         inst_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rsp_data_q <= '0;
         rsp_mis_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         inst_q     <= inst_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rsp_data_q <= rsp_data_d;
         rsp_mis_q  <= rsp_mis_d;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign req_ready    = (state_q == IDLE);
   assign rsp_valid    = (state_q == RESP);
   assign rsp_data     = rsp_data_q;
   assign rsp_misalign = rsp_mis_q;
   assign mem_inst     = inst_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_re       = (state_q == ISSUE) && is_load_q;
   assign mem_we       = (state_q == ISSUE) && is_store_q;

endmodule

// File: tb/tb_rip_lsu.sv
// Directed testbench for rip_lsu with a response scoreboard.
module tb_rip_lsu;
   import rip_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   inst_t       req_inst;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_misalign;
   inst_t       mem_inst;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_busy = 1'b0;

   typedef struct {
      logic [31:0] data;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [6:0] OPCODE_OP = 7'b0110011;

   always #5 clk = ~clk;

   rip_lsu dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_inst     (req_inst),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_misalign (rsp_misalign),
      .mem_inst     (mem_inst),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_busy     (mem_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Present one request for a single accepting edge; optionally record the
   // expected response.
   task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic push, input logic [31:0] ed,
                       input logic em);
      @(negedge clk);
      req_inst.opcode = op;
      req_inst.funct3 = f3;
      req_addr  = addr;
      req_wdata = wd;
      req_valid = 1'b1;
      chk1("req_ready_idle", req_ready, 1'b1);
      if (push) sb.push_back('{data: ed, mis: em});
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // Count cycles after acceptance until rsp_valid, watching the memory port.
   task automatic wait_rsp(input int busy_n, output int n, output int re_cnt, output int we_cnt,
                           output logic [31:0] addr_seen, output logic stable);
      logic [31:0] a0;
      logic [31:0] w0;
      bit          first;
      int          left;
      first = 1'b1;
      left = busy_n;
      n = 0;
      re_cnt = 0;
      we_cnt = 0;
      stable = 1'b1;
      addr_seen = 32'hxxxx_xxxx;
      a0 = '0;
      w0 = '0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         chk1("strobe_exclusive", mem_we & mem_re, 1'b0);
         if (mem_we || mem_re) begin
            if (mem_re) re_cnt++;
            if (mem_we) we_cnt++;
            if (first) begin
               a0 = mem_addr;
               w0 = mem_wdata;
               addr_seen = mem_addr;
               first = 1'b0;
            end else if (mem_addr !== a0 || mem_wdata !== w0) begin
               stable = 1'b0;
            end
            mem_busy = (left > 0);
            if (left > 0) left--;
         end else begin
            mem_busy = 1'b0;
         end
         if (rsp_valid) break;
      end
      mem_busy = 1'b0;
   endtask

   task automatic check_rsp(input string tag);
      exp_t e;
      chk1({tag, "_valid"}, rsp_valid, 1'b1);
      chk1({tag, "_sb_has_entry"}, sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_data"}, rsp_data, e.data);
         chk1({tag, "_misalign"}, rsp_misalign, e.mis);
      end
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      int          n;
      int          re_c;
      int          we_c;
      logic [31:0] a_s;
      logic        st;

      req_inst  = '0;
      req_addr  = '0;
      req_wdata = '0;
      mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_mem_re", mem_re, 1'b0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk1("rst_rsp_misalign", rsp_misalign, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      rstn = 1'b1;

      // Byte loads, signed and unsigned, from the top lane.
      mem_rdata = 32'h80FF_1234;
      send(OPCODE_LOAD, LB, 32'h103, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("lb_latency", n, 3);
      chk("lb_re_cycles", re_c, 1);
      check_rsp("lb");
      ack();

      send(OPCODE_LOAD, LBU, 32'h103, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("lbu_latency", n, 3);
      check_rsp("lbu");
      ack();

      mem_rdata = 32'h1234_8001;
      send(OPCODE_LOAD, LH, 32'h100, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      check_rsp("lh");
      ack();

      mem_rdata = 32'h0000_7F00;
      send(OPCODE_LOAD, LB, 32'h101, 32'h0, 1'b1, 32'h0000_007F, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      check_rsp("lb_lane1");
      ack();

      mem_rdata = 32'h1357_9BDF;
      send(OPCODE_LOAD, LW, 32'h104, 32'h0, 1'b1, 32'h1357_9BDF, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("lw_addr", a_s, 32'h104);
      check_rsp("lw");
      ack();

      // Store held off by mem_busy for four cycles.
      send(OPCODE_STORE, SW, 32'h200, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
      wait_rsp(4, n, re_c, we_c, a_s, st);
      chk("sw_we_cycles", we_c, 5);
      chk("sw_re_cycles", re_c, 0);
      chk("sw_latency", n, 6);
      chk("sw_addr", a_s, 32'h200);
      chk1("sw_stable", st, 1'b1);
      chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      check_rsp("sw");
      ack();

      send(OPCODE_STORE, SB, 32'h203, 32'h0000_00A5, 1'b1, 32'h0, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("sb_latency", n, 2);
      chk("sb_we_cycles", we_c, 1);
      chk("sb_addr", a_s, 32'h203);
      check_rsp("sb");
      ack();

      // Response back-pressure.
      mem_rdata = 32'hABCD_0000;
      send(OPCODE_LOAD, LHU, 32'h102, 32'h0, 1'b1, 32'h0000_ABCD, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("lhu_latency", n, 3);
      check_rsp("lhu");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("hold_rsp_valid", rsp_valid, 1'b1);
         chk("hold_rsp_data", rsp_data, 32'h0000_ABCD);
         chk1("hold_req_ready", req_ready, 1'b0);
      end
      ack();

      // Misaligned accesses.
      mem_rdata = 32'hCAFE_F00D;
`ifdef RIP_LSU_MISALIGN_TRAP_EN
      send(OPCODE_LOAD, LW, 32'h101, 32'h0, 1'b1, 32'h0000_0101, 1'b1);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("lw_mis_latency", n, 1);
      chk("lw_mis_re_cycles", re_c, 0);
      check_rsp("lw_mis");
      ack();
      send(OPCODE_STORE, SH, 32'h203, 32'h1111, 1'b1, 32'h0000_0203, 1'b1);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("sh_mis_we_cycles", we_c, 0);
      check_rsp("sh_mis");
      ack();
`else
      send(OPCODE_LOAD, LW, 32'h101, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("lw_mis_latency", n, 3);
      chk("lw_mis_addr", a_s, 32'h100);
      check_rsp("lw_mis");
      ack();
      send(OPCODE_STORE, SH, 32'h203, 32'h1111, 1'b1, 32'h0, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("sh_mis_addr", a_s, 32'h202);
      chk("sh_mis_we_cycles", we_c, 1);
      check_rsp("sh_mis");
      ack();
`endif

      // Non-memory opcode bypasses the memory port.
      send(OPCODE_OP, 3'b000, 32'h500, 32'h0, 1'b1, 32'h0, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("op_latency", n, 1);
      chk("op_strobes", re_c + we_c, 0);
      check_rsp("op");
      ack();

      // Reset in the middle of a load issue; the request is dropped.
      mem_rdata = 32'h5555_AAAA;
      send(OPCODE_LOAD, LW, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk1("pre_rst_mem_re", mem_re, 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk1("rst_mid_mem_re", mem_re, 1'b0);
      chk1("rst_mid_req_ready", req_ready, 1'b1);
      @(negedge clk);
      #2 rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
         chk1("post_rst_req_ready", req_ready, 1'b1);
      end

      mem_rdata = 32'h1122_3344;
      send(OPCODE_LOAD, LW, 32'h400, 32'h0, 1'b1, 32'h1122_3344, 1'b0);
      wait_rsp(0, n, re_c, we_c, a_s, st);
      chk("post_rst_lw_latency", n, 3);
      check_rsp("post_rst_lw");
      ack();

      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
